// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared types, pixel width and log2 helper for the max-pool sequencer
package pool_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int PIX_W = 6;

    // Smallest r with 2**r >= value; evaluated at elaboration for bit positions.
    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/max_pool_sequencer_if.sv
// rtl/max_pool_sequencer_if.sv - SRAM read, pooling-unit and result-buffer signals of the sequencer
interface max_pool_sequencer_if
    import pool_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int OUT_ADDR_BITS = 6
) ();

    logic                     rd_en;
    logic [ADDR_BITS-1:0]     rd_addr;
    logic [PIX_W-1:0]         rd_data;
    logic                     pool_fire;
    logic                     pool_row;
    logic [PIX_W-1:0]         pool_data;
    logic [PIX_W-1:0]         pool_result;
    logic                     wr_en;
    logic [OUT_ADDR_BITS-1:0] wr_addr;
    logic [PIX_W-1:0]         wr_data;

    modport master (
        output rd_en, rd_addr, pool_fire, pool_row, pool_data, wr_en, wr_addr, wr_data,
        input  rd_data, pool_result
    );

    modport slave (
        input  rd_en, rd_addr, pool_fire, pool_row, pool_data, wr_en, wr_addr, wr_data,
        output rd_data, pool_result
    );

endinterface

// File: rtl/pool_addr_gen.sv
// rtl/pool_addr_gen.sv - raster read address counter with pause hold and last-address flag
module pool_addr_gen
    import pool_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 advance,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 last
);

    // Counter restarts per frame, steps only on an issued read, wraps at full width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (clear) begin
            addr <= '0;
        end else if (advance) begin
            addr <= addr + ADDR_BITS'(1);
        end
    end

    assign last = &addr;

endmodule

// File: rtl/max_pool_sequencer.sv
// rtl/max_pool_sequencer.sv - raster-scans a feature map into the 2x2 pooling unit and stores pooled results
module max_pool_sequencer
    import pool_pkg::*;
#(
    parameter int INPUT_SIZE    = 16,
    parameter int ADDR_BITS     = 8,
    parameter int OUT_ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 pause,
    output logic                 busy,
    output logic                 done,
    max_pool_sequencer_if.master bus
);

    localparam int ROW_BIT = log2_ceil(INPUT_SIZE);

    state_t                   state;
    logic                     accept;
    logic                     scan_rd;
    logic [ADDR_BITS-1:0]     addr;
    logic                     addr_last;
    logic                     rd_valid;
    logic                     fire_row;
    logic                     fire_col_odd;
    logic                     wr_en_q;
    logic [OUT_ADDR_BITS-1:0] wr_cnt;

    assign accept  = (state == IDLE) && start;
    assign scan_rd = (state == SCAN) && !pause;

    pool_addr_gen #(
        .ADDR_BITS (ADDR_BITS)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .advance (scan_rd),
        .addr    (addr),
        .last    (addr_last)
    );

    // Frame control: busy covers SCAN and DRAIN, done is a single pulse in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (scan_rd && addr_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (wr_en_q && (&wr_cnt)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Fire tracks the SRAM latency exactly, so the pooling unit's pair phase only moves on real data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid     <= 1'b0;
            fire_row     <= 1'b0;
            fire_col_odd <= 1'b0;
            wr_en_q      <= 1'b0;
        end else begin
            rd_valid <= scan_rd;
            if (scan_rd) begin
                fire_row     <= addr[ROW_BIT];
                fire_col_odd <= addr[0];
            end
            wr_en_q <= rd_valid && fire_row && fire_col_odd;
        end
    end

    // Pooled-pixel index: restarts per frame, one step per completed window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
        end else if (accept) begin
            wr_cnt <= '0;
        end else if (wr_en_q) begin
            wr_cnt <= wr_cnt + OUT_ADDR_BITS'(1);
        end
    end

    assign bus.rd_en     = scan_rd;
    assign bus.rd_addr   = addr;
    assign bus.pool_fire = rd_valid;
    assign bus.pool_row  = fire_row;
    assign bus.pool_data = bus.rd_data;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_cnt;
    assign bus.wr_data   = bus.pool_result;

endmodule

// File: doc/max_pool_sequencer.md
# max_pool_sequencer

Sequencer for the 2x2 max-pooling datapath: on `start`, it raster-scans an INPUT_SIZE x INPUT_SIZE feature map out of a 1-cycle-latency SRAM. It feeds pixels to the pooling unit with correctly aligned `fire`/`row` strobes and writes each pooled result into the result buffer at sequential addresses. It sits between the feature-map SRAM, the pooling unit and the pooled-map buffer, and it is the only driver of the pooling unit's control inputs.

## Interface
- INPUT_SIZE, 16, feature-map side length in pixels; power of two, at least 4.
- ADDR_BITS, 8, input SRAM address width; equals 2*log2(INPUT_SIZE).
- OUT_ADDR_BITS, 6, result buffer address width; equals 2*log2(INPUT_SIZE/2).
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low. The same reset drives the pooling unit.
- start  in  1  begin one frame; sampled only in IDLE.
- pause  in  1  suppresses new SRAM reads while high.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of frame.
- rd_en  out  1  SRAM read strobe.
- rd_addr  out  ADDR_BITS  raster address, row*INPUT_SIZE+col.
- rd_data  in  6  SRAM data, valid the cycle after rd_en.
- pool_fire  out  1  pooling-unit fire.
- pool_row  out  1  pooling-unit row; row index bit 0 of the pixel on pool_data.
- pool_data  out  6  pixel to pooling unit; equals rd_data.
- pool_result  in  6  pooling-unit data_out.
- wr_en  out  1  result buffer write strobe.
- wr_addr  out  OUT_ADDR_BITS  pooled pixel index.
- wr_data  out  6  equals pool_result.

## Operation
- States:
  - IDLE: on start=1 go to SCAN; otherwise stay.
  - SCAN: issue reads. After the read at address INPUT_SIZE^2-1 is issued, go to DRAIN.
  - DRAIN: wait for the in-flight read, its fire and the final write. Leave on the cycle after the last wr_en and go to DONE.
  - DONE: one cycle, done=1; then IDLE.
- SCAN reads:
  - Each SCAN cycle with pause=0 drives rd_en=1 at the current address, then increments the address.
  - With pause=1: rd_en=0 and the address holds.
- Fire and row:
  - rd_valid is rd_en delayed one cycle.
  - pool_fire=rd_valid.
  - pool_row = bit log2(INPUT_SIZE) of the address registered with rd_en.
  - Fire is never asserted without valid data, so the pooling unit's pair phase (toggled per fire) stays aligned across pauses.
- Result writes:
  - wr_en is asserted the cycle after a fire with pool_row=1 and odd column (address bit 0 = 1).
  - wr_addr starts at 0 per frame and increments after each write. Frame total = (INPUT_SIZE/2)^2 writes.
- start: ignored while busy=1; no queuing.
- pause: ignored outside SCAN. In-flight reads always complete.
- Reset, including mid-frame: state IDLE, counters 0, all outputs 0. The pooling unit is reset by the same rst_n, so the next frame begins phase-aligned.
- Widths: address counters wrap naturally at their width. No arithmetic beyond increments.

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, pool_fire=0, pool_row=0, wr_en=0, wr_addr=0.
- Unpaused INPUT_SIZE=16 frame, start accepted at edge E0, cycle 1 = first cycle after E0:
  - Reads: busy=1 and rd_en=1 with rd_addr=0 in cycle 1. Reads run cycles 1..256.
  - Fires: cycles 2..257.
  - First wr_en: cycle 20, wr_addr=0, after fires of addresses 16 and 17 in cycles 18..19.
  - Last wr_en: cycle 258, wr_addr=63.
  - End: done=1 and busy=0 in cycle 259.
- Read-to-fire latency: 1 cycle.
- Fire-to-write latency: 1 cycle.
- Each pause cycle during SCAN extends the frame by exactly one cycle.

## Structure
- Shared package (`pool_pkg`): state enum {IDLE, SCAN, DRAIN, DONE}, PIX_W=6, and a log2 helper function.
- One sub-module, `pool_addr_gen`: the raster address counter with pause hold and last-address flag.
- FSM, pipeline registers and write counter stay in the top-level module.

## Test plan
- Ramp frame (pixel = addr[5:0]), no pause → 64 writes in order, wr_addr 0..63; first write in cycle 20; done in cycle 259. Expected data is the row-1 max per 2x2 window, e.g. result[0]=17.
- pause high for 5 cycles mid-SCAN plus random single-cycle pauses → identical write data and addresses; done delayed by exactly the number of pause cycles.
- start pulsed while busy, and start held high through a whole frame → exactly one frame per acceptance; back-to-back frames with a one-cycle IDLE gap.
- rst_n asserted at cycle 100, then a new start → all outputs 0 immediately; next frame's results correct (pooling phase realigned).
- Max-value corners: 2x2 windows holding 63 in each of the four positions → 63 written for every window; all-zero frame → all writes 0.
